// File: rtl/regread_stage.sv
// Register-read pipeline stage: reads operands for a decoded instruction and holds up to two
// entries (HEAD, SKID) for execute. Optional writeback bypass enabled by defining WB_BYPASS_EN.
module regread_stage #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [3:0]        in_src1,
    input  logic [3:0]        in_src2,
    input  logic [3:0]        in_dst,
    input  logic              in_wen,
    input  logic [DATA_W-1:0] in_imm,
    output logic [3:0]        rf_src1,
    output logic [3:0]        rf_src2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              wb_wen,
    input  logic [3:0]        wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [3:0]        out_dst,
    output logic              out_wen,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm
);

    typedef enum logic [1:0] {EMPTY, FULL, SKID_FULL} state_t;

    typedef struct packed {
        logic [3:0]        op;
        logic [3:0]        dst;
        logic              wen;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
    } entry_t;

    state_t state, next_state;
    entry_t head, skid, cap, head_upd, skid_upd;
    logic   load_head_cap, load_head_skid, load_skid_cap;
    logic   in_fire, out_fire;

    assign rf_src1   = in_src1;
    assign rf_src2   = in_src2;
    assign in_ready  = (state != SKID_FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

`ifdef WB_BYPASS_EN
    // Source ids are kept per entry so held operands can track later writebacks.
    logic [3:0] head_s1, head_s2, skid_s1, skid_s2;

    function automatic logic wb_hit(input logic [3:0] id);
        return wb_wen && (wb_dst != 4'd0) && (wb_dst == id);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_s1 <= '0;
            head_s2 <= '0;
            skid_s1 <= '0;
            skid_s2 <= '0;
        end else begin
            if (load_head_cap) begin
                head_s1 <= in_src1;
                head_s2 <= in_src2;
            end else if (load_head_skid) begin
                head_s1 <= skid_s1;
                head_s2 <= skid_s2;
            end
            if (load_skid_cap) begin
                skid_s1 <= in_src1;
                skid_s2 <= in_src2;
            end
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_wen, wb_dst, wb_data};
`endif

    // Register 0 reads as zero regardless of what the register file returns.
    always_comb begin
        cap.op   = in_op;
        cap.dst  = in_dst;
        cap.wen  = in_wen;
        cap.imm  = in_imm;
        cap.a    = (in_src1 == 4'd0) ? '0 : rf_data1;
        cap.b    = (in_src2 == 4'd0) ? '0 : rf_data2;
        head_upd = head;
        skid_upd = skid;
`ifdef WB_BYPASS_EN
        if (wb_hit(in_src1)) cap.a = wb_data;
        if (wb_hit(in_src2)) cap.b = wb_data;
        if (wb_hit(head_s1)) head_upd.a = wb_data;
        if (wb_hit(head_s2)) head_upd.b = wb_data;
        if (wb_hit(skid_s1)) skid_upd.a = wb_data;
        if (wb_hit(skid_s2)) skid_upd.b = wb_data;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= next_state;
    end

    always_comb begin
        next_state     = state;
        load_head_cap  = 1'b0;
        load_head_skid = 1'b0;
        load_skid_cap  = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    next_state    = FULL;
                    load_head_cap = 1'b1;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    load_head_cap = 1'b1;
                end else if (in_fire) begin
                    next_state    = SKID_FULL;
                    load_skid_cap = 1'b1;
                end else if (out_fire) begin
                    next_state = EMPTY;
                end
            end
            SKID_FULL: begin
                if (out_fire) begin
                    next_state     = FULL;
                    load_head_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
        // Flush discards everything held plus any same-cycle capture.
        if (flush) begin
            next_state     = EMPTY;
            load_head_cap  = 1'b0;
            load_head_skid = 1'b0;
            load_skid_cap  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head_cap)       head <= cap;
            else if (load_head_skid) head <= skid_upd;
            else                     head <= head_upd;
            if (load_skid_cap)       skid <= cap;
            else                     skid <= skid_upd;
        end
    end

    assign out_op  = head.op;
    assign out_dst = head.dst;
    assign out_wen = head.wen;
    assign out_a   = head.a;
    assign out_b   = head.b;
    assign out_imm = head.imm;

endmodule

// File: doc/regread_stage.md
REGREAD_STAGE -- requirements
Module: regread_stage

Interface
REQ-001 Parameter: DATA_W, 16, operand and immediate width in bits.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 in_valid  in  1  decoded instruction present.
REQ-005 in_ready  out  1  stage can accept an instruction.
REQ-006 in_op  in  4  opcode, passed through.
REQ-007 in_src1, in_src2  in  4 each  source register ids.
REQ-008 in_dst  in  4  destination register id.
REQ-009 in_wen  in  1  instruction writes in_dst.
REQ-010 in_imm  in  DATA_W  immediate, passed through.
REQ-011 rf_src1, rf_src2  out  4 each  register-file read addresses.
REQ-012 rf_data1, rf_data2  in  DATA_W each  register-file read data, combinational from rf_src1/rf_src2.
REQ-013 wb_wen, wb_dst, wb_data  in  1/4/DATA_W  writeback port, same values driven to the register-file write port this cycle.
REQ-014 flush  in  1  synchronous discard of all held instructions.
REQ-015 out_valid  out  1  head entry valid.
REQ-016 out_ready  in  1  execute stage accepts head.
REQ-017 out_op, out_dst, out_wen, out_a, out_b, out_imm  out  4/4/1/DATA_W/DATA_W/DATA_W  head entry fields.

Function
REQ-018 rf_src1 = in_src1 and rf_src2 = in_src2, combinational.
REQ-019 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-020 Two-entry in-order buffer (HEAD, SKID); state machine EMPTY, FULL, SKID_FULL.
REQ-021 EMPTY: input fire -> FULL (entry captured into HEAD).
REQ-022 FULL: input and output fire -> FULL, HEAD replaced by new entry; input fire only -> SKID_FULL, new entry into SKID; output fire only -> EMPTY; neither -> FULL, hold.
REQ-023 SKID_FULL: output fire -> FULL, SKID moves to HEAD; else hold.
REQ-024 in_ready = (state != SKID_FULL); out_valid = (state != EMPTY); both decoded from state register only.
REQ-025 Captured out_a/out_b = rf_data1/rf_data2, except register id 0 always captures 0.
REQ-026 Latency: instruction accepted in cycle N is presentable on out_* in cycle N+1 when buffer was EMPTY or head fired in N.
REQ-027 out_op, out_dst, out_wen, out_imm pass through unmodified.
REQ-028 flush: next state EMPTY; input fire in the same cycle is discarded; out fire in that cycle still counts as consumed.
REQ-029 Order preserved: SKID never presented before HEAD.

Reset
REQ-030 rst asserted: state EMPTY, out_valid 0, in_ready 1, all out_* data fields 0, immediately and independent of clk.
REQ-031 rst mid-transfer drops any held entries; rst overrides flush and every handshake.
REQ-032 After rst deasserts, first input fire is accepted on the next rising edge.

Configuration
REQ-033 Macro WB_BYPASS_EN.
REQ-034 Defined: at capture, operand N takes wb_data when wb_wen=1, wb_dst=in_srcN, wb_dst!=0; also each cycle any held HEAD/SKID operand whose source id matches an active nonzero wb_dst is overwritten with wb_data.
REQ-035 Undefined: operands are rf_data captured as-is, held operands never updated; software schedules around write-to-read hazards.
REQ-036 Interface and handshake timing identical in both builds.

Verification
REQ-037 Reset: rst=1 mid-run with both entries held -> out_valid=0, in_ready=1, out_a=0 within the same cycle.
REQ-038 Basic: R3=16'h1234, R5=16'h00FF; issue src1=3, src2=5, out_ready=1 -> next cycle out_a=16'h1234, out_b=16'h00FF, out_valid=1.
REQ-039 Backpressure: out_ready=0, issue 3 instructions back-to-back -> first two held, in_ready=0 after second, third held upstream; raise out_ready -> all three emerge in order, none lost or duplicated.
REQ-040 Register 0: src1=0 with rf_data1 forced 16'hFFFF and wb_wen=1, wb_dst=0, wb_data=16'hAAAA -> out_a=0.
REQ-041 Bypass (WB_BYPASS_EN): issue src1=7 while wb_wen=1, wb_dst=7, wb_data=16'hBEEF, rf_data1=16'h0001 -> out_a=16'hBEEF; entry held with out_ready=0, later wb to R7 of 16'hCAFE -> out_a=16'hCAFE. Without macro -> out_a=16'h0001, stays 16'h0001.
REQ-042 Flush: SKID_FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and same-cycle inputs never appear on out_*.
